// File: rtl/velox_sched_pkg.sv
// Shared types and helpers for the velox LED blink scheduler.
package velox_sched_pkg;

  localparam int CNTW_DEF = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ON   = 2'd1,
    ST_OFF  = 2'd2,
    ST_GAP  = 2'd3
  } state_t;

  // Blink unit length in clock cycles; 64-bit math so large clocks do not overflow.
  function automatic int calc_unit(input longint unsigned f_hz, input longint unsigned ms);
    return int'((f_hz * ms) / 64'd1000);
  endfunction

endpackage

// File: rtl/velox_tick_div.sv
// U-cycle prescaler: one-cycle tick every DIV cycles, restartable by a synchronous clear.
module velox_tick_div #(
  parameter int DIV = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  output logic tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (clr || (r_cnt == LAST)) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign tick = (r_cnt == LAST);

endmodule

// File: rtl/velox_blink_sched.sv
// Round-robin scheduler sharing one status LED among nreq blink-code requesters.
// Optional VELOX_SCHED_HEARTBEAT_EN: LED toggles every unit while idle with no request.
//   state | meaning
//   IDLE  | waiting; grants next requester at/after ptr
//   ON    | LED lit for one unit
//   OFF   | LED dark for one unit, one pulse consumed
//   GAP   | dark gap_units units, then done pulse
module velox_blink_sched
  import velox_sched_pkg::*;
#(
  parameter int clk_freq_hz = 50_000,
  parameter int unit_ms     = 250,
  parameter int gap_units   = 4,
  parameter int nreq        = 4,
  parameter int cntw        = CNTW_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [nreq-1:0]      req,
  input  logic [nreq*cntw-1:0] count,
  output logic [nreq-1:0]      done,
  output logic                 busy,
  output logic                 q
);

  localparam int U   = calc_unit(longint'(clk_freq_hz), longint'(unit_ms));
  localparam int IW  = $clog2(nreq);
  localparam int IW1 = IW + 1;
  localparam int GW  = (gap_units > 1) ? $clog2(gap_units) : 1;
  localparam logic [GW-1:0] GLAST = GW'(gap_units - 1);

  if ((U < 1) || (gap_units < 1) || (nreq < 2) || (nreq > 8)) begin : g_param_chk
    $error("velox_blink_sched: illegal parameter set");
  end

  state_t            r_state, w_state_n;
  logic              r_q, w_q_n;
  logic              r_busy;
  logic [nreq-1:0]   r_done, w_done_n;
  logic [cntw-1:0]   r_rem, w_rem_n;
  logic [GW-1:0]     r_gcnt, w_gcnt_n;
  logic [IW-1:0]     r_ptr, w_ptr_n;
  logic [IW-1:0]     r_idx, w_idx_n;
  logic              w_clr, w_tick;

  logic [cntw-1:0]   w_cnt [nreq];
  logic [2*nreq-1:0] w_req2;
  logic [nreq-1:0]   w_rot;
  logic              w_any;
  logic [IW-1:0]     w_off, w_gnt, w_ptr_inc;
  logic [IW:0]       w_sum;

  for (genvar g = 0; g < nreq; g++) begin : g_cnt
    assign w_cnt[g] = count[g*cntw +: cntw];
  end

  // Rotate requests so bit 0 is the requester at ptr; lowest set bit wins.
  assign w_req2 = {req, req};
  assign w_rot  = w_req2[r_ptr +: nreq];

  always_comb begin
    w_any = 1'b0;
    w_off = '0;
    for (int j = nreq - 1; j >= 0; j--) begin
      if (w_rot[j]) begin
        w_any = 1'b1;
        w_off = IW'(j);
      end
    end
    w_sum     = {1'b0, r_ptr} + {1'b0, w_off};
    w_gnt     = (w_sum >= IW1'(nreq)) ? IW'(w_sum - IW1'(nreq)) : IW'(w_sum);
    w_ptr_inc = (w_gnt == IW'(nreq - 1)) ? '0 : w_gnt + 1'b1;
  end

  velox_tick_div #(.DIV(U)) u_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (w_clr),
    .tick  (w_tick)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_q     <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= '0;
      r_rem   <= '0;
      r_gcnt  <= '0;
      r_ptr   <= '0;
      r_idx   <= '0;
    end else begin
      r_state <= w_state_n;
      r_q     <= w_q_n;
      r_busy  <= (w_state_n != ST_IDLE);
      r_done  <= w_done_n;
      r_rem   <= w_rem_n;
      r_gcnt  <= w_gcnt_n;
      r_ptr   <= w_ptr_n;
      r_idx   <= w_idx_n;
    end
  end

  always_comb begin
    w_state_n = r_state;
    w_q_n     = r_q;
    w_done_n  = '0;
    w_rem_n   = r_rem;
    w_gcnt_n  = r_gcnt;
    w_ptr_n   = r_ptr;
    w_idx_n   = r_idx;
    w_clr     = 1'b0;
    case (r_state)
      ST_IDLE: begin
`ifdef VELOX_SCHED_HEARTBEAT_EN
        if (w_tick) w_q_n = ~r_q;
`else
        w_q_n = 1'b0;
`endif
        if (w_any) begin
          w_idx_n = w_gnt;
          w_ptr_n = w_ptr_inc;
          w_rem_n = w_cnt[w_gnt];
          if (w_cnt[w_gnt] != '0) begin
            w_state_n = ST_ON;
            w_q_n     = 1'b1;
            w_clr     = 1'b1;
          end else begin
            w_done_n[w_gnt] = 1'b1;
          end
        end
      end
      ST_ON: begin
        w_q_n = 1'b1;
        if (w_tick) begin
          w_state_n = ST_OFF;
          w_q_n     = 1'b0;
          w_clr     = 1'b1;
        end
      end
      ST_OFF: begin
        w_q_n = 1'b0;
        if (w_tick) begin
          w_rem_n = r_rem - 1'b1;
          w_clr   = 1'b1;
          if (r_rem > cntw'(1)) begin
            w_state_n = ST_ON;
            w_q_n     = 1'b1;
          end else begin
            w_state_n = ST_GAP;
            w_gcnt_n  = '0;
          end
        end
      end
      ST_GAP: begin
        w_q_n = 1'b0;
        if (w_tick) begin
          if (r_gcnt == GLAST) begin
            w_state_n       = ST_IDLE;
            w_done_n[r_idx] = 1'b1;
            w_gcnt_n        = '0;
            w_clr           = 1'b1;
          end else begin
            w_gcnt_n = r_gcnt + 1'b1;
          end
        end
      end
      default: begin
        w_state_n = ST_IDLE;
        w_q_n     = 1'b0;
      end
    endcase
  end

  assign q    = r_q;
  assign busy = r_busy;
  assign done = r_done;

endmodule

// File: tb/tb_velox_blink_sched.sv
// Directed bench for velox_blink_sched: U=100 cycles, gap 4 units, 4 requesters.
module tb_velox_blink_sched;

  localparam int UC = 100;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req;
  logic [15:0] count;
  logic [3:0]  done;
  logic        busy;
  logic        q;

  int n_cmp = 0;
  int n_bad = 0;

  logic       sq [4096];
  logic       sb [4096];
  logic [3:0] sd [4096];

  always #5 clk = ~clk;

  velox_blink_sched #(
    .clk_freq_hz (50_000),
    .unit_ms     (2),
    .gap_units   (4),
    .nreq        (4),
    .cntw        (4)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (req),
    .count (count),
    .done  (done),
    .busy  (busy),
    .q     (q)
  );

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  // Sample index 0 is the negedge right after the grant edge.
  task automatic capture(input int n, input int chg_at, input logic [3:0] chg_req,
                         input logic [15:0] chg_cnt);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      sq[i] = q;
      sb[i] = busy;
      sd[i] = done;
      if (i == chg_at) begin
        req   = chg_req;
        count = chg_cnt;
      end
    end
  endtask

  function automatic int wave_err(input int npulse, input int len);
    int e = 0;
    logic ex;
    for (int i = 0; i < len; i++) begin
      ex = (i < 2 * npulse * UC) && (((i / UC) % 2) == 0);
      if (sq[i] !== ex) e++;
    end
    return e;
  endfunction

  function automatic int rises(input int len);
    int r = 0;
    if (sq[0] === 1'b1) r++;
    for (int i = 1; i < len; i++) if (sq[i] === 1'b1 && sq[i-1] === 1'b0) r++;
    return r;
  endfunction

  function automatic int first_done(input int len);
    for (int i = 0; i < len; i++) if (sd[i] !== 4'b0000) return i;
    return -1;
  endfunction

  task automatic wait_idle();
    int k = 0;
    while (busy !== 1'b0 && k < 3000) begin
      @(negedge clk);
      k++;
    end
    chk("drain_idle", busy, 0);
  endtask

  initial begin
    int ev_t [5];
    int ev_v [5];
    int nev;
    int acc;
    int exp_t [5] = '{600, 1201, 1802, 2403, 3004};
    int exp_v [5] = '{1, 2, 4, 8, 1};

    rst_n = 1'b0;
    req   = 4'b0000;
    count = 16'h0000;

    // reset state
    repeat (3) @(negedge clk);
    chk("rst_q", q, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    chk("post_rst_q", q, 0);
    chk("post_rst_busy", busy, 0);
    chk("post_rst_done", done, 0);

    // single code, requester 1, three pulses
    req = 4'b0010;
    count = 16'h0030;
    capture(1010, 0, 4'b0000, 16'h0030);
    chk("single_q_first", sq[0], 1);
    chk("single_busy_first", sb[0], 1);
    chk("single_wave", wave_err(3, 1010), 0);
    chk("single_rises", rises(1010), 3);
    chk("single_done_at", first_done(1010), 1000);
    chk("single_done_val", sd[1000], 4'b0010);
    chk("single_done_len", sd[1001], 0);
    chk("single_busy_999", sb[999], 1);
    chk("single_busy_1000", sb[1000], 0);

    // zero count, requester 2
    req = 4'b0100;
    count = 16'h0000;
    capture(5, 0, 4'b0000, 16'h0000);
    chk("zero_done_val", sd[0], 4'b0100);
    chk("zero_done_len", sd[1], 0);
    acc = 0;
    for (int i = 0; i < 5; i++) acc += int'(sb[i]) + int'(sq[i]);
    chk("zero_no_busy_q", acc, 0);

    // mid-sequence changes ignored: latched count 2 completes
    req = 4'b0001;
    count = 16'h0002;
    capture(820, 50, 4'b0000, 16'hFFFF);
    chk("mid_wave", wave_err(2, 820), 0);
    chk("mid_rises", rises(820), 2);
    chk("mid_done_at", first_done(820), 800);
    chk("mid_done_val", sd[800], 4'b0001);

    // reset during OFF aborts with no done
    req = 4'b1000;
    count = 16'h2000;
    capture(150, 0, 4'b0000, 16'h2000);
    chk("abort_busy_pre", sb[149], 1);
    chk("abort_q_off", sq[149], 0);
    rst_n = 1'b0;
    #1;
    chk("abort_q", q, 0);
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    acc = 0;
    repeat (5) begin
      @(negedge clk);
      acc += int'(done != 4'b0000) + int'(busy) + int'(q);
    end
    chk("abort_quiet", acc, 0);
    rst_n = 1'b1;
    @(negedge clk);
    req = 4'b1001;
    count = 16'h1001;
    capture(610, 0, 4'b0000, 16'h1001);
    chk("ptr0_done_at", first_done(610), 600);
    chk("ptr0_done_val", sd[600], 4'b0001);
    chk("ptr0_wave", wave_err(1, 610), 0);

    // round-robin from ptr 0, all requesters held with count 1
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    req = 4'b1111;
    count = 16'h1111;
    capture(3010, 3009, 4'b0000, 16'h1111);
    nev = 0;
    for (int i = 0; i < 3010; i++) begin
      if (sd[i] !== 4'b0000) begin
        if (nev < 5) begin
          ev_t[nev] = i;
          ev_v[nev] = int'(sd[i]);
        end
        nev++;
      end
    end
    chk("rr_n_done", nev, 5);
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("rr_t%0d", k), (k < nev) ? ev_t[k] : -1, exp_t[k]);
      chk($sformatf("rr_v%0d", k), (k < nev) ? ev_v[k] : -1, exp_v[k]);
    end
    chk("rr_idle_gap_busy", sb[600], 0);
    chk("rr_idle_gap_q", sq[600], 0);
    chk("rr_regrant_q", sq[601], 1);
    wait_idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
